// File: rtl/prog_clk_div.sv
// Programmable clock divider: period and high time set at runtime through a
// valid/ready handshake, with new settings staged in a shadow until the next wrap.
module prog_clk_div #(
   parameter int unsigned WIDTH     = 16,
   parameter int unsigned DIV_INIT  = 3,
   parameter int unsigned HIGH_INIT = 1
) (
   input  logic             CLK_IN,
   input  logic             RST_N,
   input  logic             EN,
   input  logic             CFG_VALID,
   output logic             CFG_READY,
   input  logic [WIDTH-1:0] CFG_DIV,
   input  logic [WIDTH-1:0] CFG_HIGH,
   output logic             CLK_OUT,
   output logic             TICK,
   output logic             ERR
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      PEND = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] DIV_RST  = WIDTH'(DIV_INIT);
   localparam logic [WIDTH-1:0] HIGH_RST = WIDTH'(HIGH_INIT);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] div_q, div_d;
   logic [WIDTH-1:0] high_q, high_d;
   logic [WIDTH-1:0] sdiv_q, sdiv_d;
   logic [WIDTH-1:0] shigh_q, shigh_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             clk_q, clk_d;
   logic             tick_q, tick_d;
   logic             err_q, err_d;

   logic             hs;
   logic             cfg_ok;
   logic             wrap;
   logic [WIDTH-1:0] cnt_inc;

   always_comb begin
      CFG_READY = (state_q != PEND);
      hs        = CFG_VALID && CFG_READY;
      cfg_ok    = (CFG_DIV >= WIDTH'(2)) && (CFG_HIGH != '0) && (CFG_HIGH < CFG_DIV);
      cnt_inc   = cnt_q + WIDTH'(1);
      wrap      = (cnt_q == div_q - WIDTH'(1));
   end

   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      high_d  = high_q;
      sdiv_d  = sdiv_q;
      shigh_d = shigh_q;
      cnt_d   = cnt_q;
      clk_d   = clk_q;
      tick_d  = 1'b0;
      err_d   = err_q;

      // A rejected offer is still consumed; only the sticky flag records it.
      if (hs) begin
         err_d = !cfg_ok;
      end

      case (state_q)
         IDLE: begin
            if (hs && cfg_ok) begin
               div_d  = CFG_DIV;
               high_d = CFG_HIGH;
            end
            if (EN) begin
               state_d = RUN;
               cnt_d   = '0;
               clk_d   = 1'b1;
            end
         end
         RUN, PEND: begin
            if (!EN) begin
               state_d = IDLE;
               cnt_d   = '0;
               clk_d   = 1'b0;
               if (state_q == PEND) begin
                  div_d  = sdiv_q;
                  high_d = shigh_q;
               end
               if (hs && cfg_ok) begin
                  div_d  = CFG_DIV;
                  high_d = CFG_HIGH;
               end
            end else begin
               if (wrap) begin
                  cnt_d  = '0;
                  clk_d  = 1'b1;
                  tick_d = 1'b1;
                  // Promotion at the wrap edge keeps the outgoing period whole.
                  if (state_q == PEND) begin
                     div_d   = sdiv_q;
                     high_d  = shigh_q;
                     state_d = RUN;
                  end
               end else begin
                  cnt_d = cnt_inc;
                  clk_d = (cnt_inc < high_q);
               end
               if (hs && cfg_ok) begin
                  sdiv_d  = CFG_DIV;
                  shigh_d = CFG_HIGH;
                  state_d = PEND;
               end
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            clk_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge CLK_IN or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= IDLE;
         div_q   <= DIV_RST;
         high_q  <= HIGH_RST;
         sdiv_q  <= DIV_RST;
         shigh_q <= HIGH_RST;
         cnt_q   <= '0;
         clk_q   <= 1'b0;
         tick_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         high_q  <= high_d;
         sdiv_q  <= sdiv_d;
         shigh_q <= shigh_d;
         cnt_q   <= cnt_d;
         clk_q   <= clk_d;
         tick_q  <= tick_d;
         err_q   <= err_d;
      end
   end

   assign CLK_OUT = clk_q;
   assign TICK    = tick_q;
   assign ERR     = err_q;

endmodule

// File: tb/tb_prog_clk_div.sv
// Bench for prog_clk_div: directed scenarios plus random traffic checked
// against a period-position model; a 4-bit instance covers the counter ceiling.
module tb_prog_clk_div;

   logic        CLK_IN = 1'b0;
   logic        RST_N  = 1'b0;
   logic        EN = 1'b0, CFG_VALID = 1'b0;
   logic [15:0] CFG_DIV = '0, CFG_HIGH = '0;
   logic        CFG_READY, CLK_OUT, TICK, ERR;

   logic        en2 = 1'b0, v2 = 1'b0;
   logic [3:0]  d2 = '0, h2 = '0;
   logic        rdy2, clk2, tick2, err2;

   int total = 0;
   int bad   = 0;

   // Model: running flag, position inside the current period, active/shadow pairs.
   int m_run, m_pos, m_first, m_div, m_high, m_sdiv, m_shigh, m_pend, m_err;

   always #5 CLK_IN = ~CLK_IN;

   prog_clk_div #(.WIDTH(16), .DIV_INIT(3), .HIGH_INIT(1)) dut (
      .CLK_IN(CLK_IN), .RST_N(RST_N), .EN(EN), .CFG_VALID(CFG_VALID),
      .CFG_READY(CFG_READY), .CFG_DIV(CFG_DIV), .CFG_HIGH(CFG_HIGH),
      .CLK_OUT(CLK_OUT), .TICK(TICK), .ERR(ERR)
   );

   prog_clk_div #(.WIDTH(4), .DIV_INIT(15), .HIGH_INIT(14)) dut4 (
      .CLK_IN(CLK_IN), .RST_N(RST_N), .EN(en2), .CFG_VALID(v2),
      .CFG_READY(rdy2), .CFG_DIV(d2), .CFG_HIGH(h2),
      .CLK_OUT(clk2), .TICK(tick2), .ERR(err2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      m_run = 0; m_pos = 0; m_first = 0; m_pend = 0; m_err = 0;
      m_div = 3; m_high = 1; m_sdiv = 3; m_shigh = 1;
   endtask

   task automatic m_edge(input bit en, input bit v, input int d, input int h);
      bit hs, ok;
      hs = v && (m_pend == 0);
      ok = (d >= 2) && (h >= 1) && (h < d);
      if (hs) m_err = ok ? 0 : 1;
      if (m_run == 0) begin
         if (hs && ok) begin m_div = d; m_high = h; end
         if (en) begin m_run = 1; m_pos = 0; m_first = 1; end
      end else if (!en) begin
         if (m_pend != 0) begin m_div = m_sdiv; m_high = m_shigh; m_pend = 0; end
         if (hs && ok) begin m_div = d; m_high = h; end
         m_run = 0; m_pos = 0;
      end else begin
         if (m_pos == m_div - 1) begin
            m_pos = 0; m_first = 0;
            if (m_pend != 0) begin m_div = m_sdiv; m_high = m_shigh; m_pend = 0; end
         end else begin
            m_pos++;
         end
         if (hs && ok) begin m_sdiv = d; m_shigh = h; m_pend = 1; end
      end
   endtask

   task automatic check_outputs();
      chk("clk_out", 32'(CLK_OUT), 32'((m_run != 0) && (m_pos < m_high)));
      chk("tick", 32'(TICK), 32'((m_run != 0) && (m_pos == 0) && (m_first == 0)));
      chk("err", 32'(ERR), 32'(m_err));
      chk("cfg_ready", 32'(CFG_READY), 32'(m_pend == 0));
   endtask

   task automatic step(input bit en, input bit v, input int d, input int h);
      EN = en; CFG_VALID = v; CFG_DIV = 16'(d); CFG_HIGH = 16'(h);
      @(posedge CLK_IN);
      m_edge(en, v, d, h);
      #1;
      check_outputs();
   endtask

   initial begin
      int guard;
      m_reset();

      #3;
      chk("rst_clk", 32'(CLK_OUT), 32'(0));
      chk("rst_tick", 32'(TICK), 32'(0));
      chk("rst_err", 32'(ERR), 32'(0));
      chk("rst_ready", 32'(CFG_READY), 32'(1));
      #9 RST_N = 1'b1;

      // Defaults: 1,0,0 repeating with TICK on each restart.
      for (int i = 0; i < 9; i++) begin
         step(1, 0, 0, 0);
         chk("def_pat_clk", 32'(CLK_OUT), 32'((i % 3) == 0));
         chk("def_pat_tick", 32'(TICK), 32'((i > 0) && ((i % 3) == 0)));
      end

      // Reconfigure at cnt=0: old period finishes, then 5 high / 5 low.
      guard = 0;
      while (m_pos != 0 && guard < 10) begin step(1, 0, 0, 0); guard++; end
      chk("sync_pos0", 32'(m_pos), 32'(0));
      step(1, 1, 10, 5);
      chk("pend_ready", 32'(CFG_READY), 32'(0));
      for (int i = 0; i < 24; i++) step(1, 0, 0, 0);

      // Rejected configurations leave the waveform alone; a good one clears ERR.
      step(1, 1, 1, 1);
      chk("rej_div1", 32'(ERR), 32'(1));
      step(1, 0, 0, 0);
      step(1, 1, 4, 4);
      chk("rej_hi_eq", 32'(ERR), 32'(1));
      step(1, 1, 4, 0);
      chk("rej_hi0", 32'(ERR), 32'(1));
      for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
      step(1, 1, 4, 2);
      chk("good_clr", 32'(ERR), 32'(0));
      for (int i = 0; i < 16; i++) step(1, 0, 0, 0);

      // Drop EN while a shadow waits; the shadow becomes active for the restart.
      step(1, 1, 6, 3);
      step(0, 0, 0, 0);
      chk("drop_clk", 32'(CLK_OUT), 32'(0));
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      for (int i = 0; i < 14; i++) begin
         step(1, 0, 0, 0);
         chk("reen_clk", 32'(CLK_OUT), 32'((i % 6) < 3));
      end

      // Asynchronous reset in the high phase with a shadow pending.
      guard = 0;
      while (m_pos != m_div - 1 && guard < 10) begin step(1, 0, 0, 0); guard++; end
      step(1, 1, 8, 4);
      chk("pre_rst_high", 32'(CLK_OUT), 32'(1));
      #2 RST_N = 1'b0;
      #1;
      m_reset();
      chk("arst_clk", 32'(CLK_OUT), 32'(0));
      chk("arst_ready", 32'(CFG_READY), 32'(1));
      chk("arst_tick", 32'(TICK), 32'(0));
      #3 RST_N = 1'b1;
      for (int i = 0; i < 9; i++) begin
         step(1, 0, 0, 0);
         chk("post_rst_clk", 32'(CLK_OUT), 32'((i % 3) == 0));
      end

      // Random traffic, mixing valid and invalid offers and EN drops.
      for (int i = 0; i < 400; i++) begin
         step(($urandom % 16) != 0, ($urandom % 4) == 0,
              int'($urandom_range(0, 11)), int'($urandom_range(0, 11)));
      end

      // 4-bit instance at div=15/high=14: one low cycle per period, no overflow.
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
      for (int k = 0; k < 35; k++) begin
         en2 = 1'b1;
         step(0, 0, 0, 0);
         chk("w4_clk", 32'(clk2), 32'((k % 15) < 14));
         chk("w4_tick", 32'(tick2), 32'((k > 0) && ((k % 15) == 0)));
         chk("w4_ready", 32'(rdy2), 32'(1));
         chk("w4_err", 32'(err2), 32'(0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
